// File: rtl/l2_evict_buffer.sv
// Eviction write buffer between the L2 cache and the L2 memory arbiter.
// Dirty lines queue in a circular FIFO and drain one at a time to the arbiter.
// A repeat eviction coalesces into an unlocked matching entry. Lookups are
// forwarded from the youngest matching entry, so a refill never reads stale pmem.
module l2_evict_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         l2_evict_write,
    input  logic [31:0]  l2_evict_addr,
    input  logic [255:0] l2_evict_wdata,
    output logic         evict_resp,
    input  logic [31:0]  lookup_addr,
    output logic         lookup_hit,
    output logic [255:0] lookup_rdata,
    output logic         ewb_write,
    output logic [31:0]  ewb_addr,
    output logic [255:0] ewb_wdata,
    input  logic         arb_ewb_resp,
    output logic         ewb_empty,
    output logic         ewb_full
);

    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_RETIRE = 2'd2;

    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [26:0]        tag_q   [DEPTH];
    logic [26:0]        tag_d   [DEPTH];
    logic [255:0]       data_q  [DEPTH];
    logic [255:0]       data_d  [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         state_q, state_d;
    logic               evict_resp_q, evict_resp_d;

    logic [26:0]        evict_tag;
    logic [26:0]        lookup_tag;
    logic               head_locked;
    logic               coal_hit;
    logic [PTR_W-1:0]   coal_idx;
    logic               fwd_hit;
    logic [PTR_W-1:0]   fwd_idx;
    logic               accept;
    logic               enqueue;
    logic               retire;
    logic               unused_addr_bits;

    assign evict_tag   = l2_evict_addr[31:5];
    assign lookup_tag  = lookup_addr[31:5];
    assign head_locked = (state_q == ST_DRAIN) || (state_q == ST_RETIRE);
    assign unused_addr_bits = ^{l2_evict_addr[4:0], lookup_addr[4:0]};

    // Walk entries oldest-to-youngest so the last match found is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = '0;
        coal_hit = 1'b0;
        coal_idx = '0;
        fwd_hit  = 1'b0;
        fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if (valid_q[idx] && (tag_q[idx] == evict_tag) &&
                !(head_locked && (idx == head_q))) begin
                coal_hit = 1'b1;
                coal_idx = idx;
            end
            if (valid_q[idx] && (tag_q[idx] == lookup_tag)) begin
                fwd_hit = 1'b1;
                fwd_idx = idx;
            end
        end
    end

    // A request in its evict_resp cycle is never re-accepted, so a held request enqueues once.
    assign accept  = l2_evict_write && !evict_resp_q && (coal_hit || (count_q < FULL_CNT));
    assign enqueue = accept && !coal_hit;
    assign retire  = (state_q == ST_RETIRE);

    // Next-state for storage, pointers, count and drain FSM.
    always_comb begin
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        state_d      = state_q;
        evict_resp_d = accept;

        if (accept) begin
            if (coal_hit) begin
                data_d[coal_idx] = l2_evict_wdata;
            end else begin
                valid_d[tail_q] = 1'b1;
                tag_d[tail_q]   = evict_tag;
                data_d[tail_q]  = l2_evict_wdata;
                tail_d          = tail_q + 1'b1;
            end
        end

        if (retire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end

        unique case ({enqueue, retire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        unique case (state_q)
            ST_IDLE:   if (count_q != '0) state_d = ST_DRAIN;
            ST_DRAIN:  if (arb_ewb_resp) state_d = ST_RETIRE;
            ST_RETIRE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            state_q      <= ST_IDLE;
            evict_resp_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            state_q      <= state_d;
            evict_resp_q <= evict_resp_d;
        end
    end

    // Tag and line storage; contents are qualified by valid_q, so no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign evict_resp   = evict_resp_q;
    assign ewb_write    = (state_q == ST_DRAIN);
    assign ewb_addr     = {tag_q[head_q], 5'b0};
    assign ewb_wdata    = data_q[head_q];
    assign lookup_hit   = fwd_hit;
    assign lookup_rdata = fwd_hit ? data_q[fwd_idx] : '0;
    assign ewb_empty    = (count_q == '0);
    assign ewb_full     = (count_q == FULL_CNT);

endmodule

// File: tb/tb_l2_evict_buffer.sv
// Directed bench for l2_evict_buffer with a drain-order scoreboard.
module tb_l2_evict_buffer;

    typedef struct packed {
        logic [31:0]  addr;
        logic [255:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         l2_evict_write;
    logic [31:0]  l2_evict_addr;
    logic [255:0] l2_evict_wdata;
    logic         evict_resp;
    logic [31:0]  lookup_addr;
    logic         lookup_hit;
    logic [255:0] lookup_rdata;
    logic         ewb_write;
    logic [31:0]  ewb_addr;
    logic [255:0] ewb_wdata;
    logic         arb_ewb_resp;
    logic         ewb_empty;
    logic         ewb_full;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    l2_evict_buffer #(.DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .l2_evict_write (l2_evict_write),
        .l2_evict_addr  (l2_evict_addr),
        .l2_evict_wdata (l2_evict_wdata),
        .evict_resp     (evict_resp),
        .lookup_addr    (lookup_addr),
        .lookup_hit     (lookup_hit),
        .lookup_rdata   (lookup_rdata),
        .ewb_write      (ewb_write),
        .ewb_addr       (ewb_addr),
        .ewb_wdata      (ewb_wdata),
        .arb_ewb_resp   (arb_ewb_resp),
        .ewb_empty      (ewb_empty),
        .ewb_full       (ewb_full)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] pat(input logic [31:0] s);
        return {s, ~s, s + 32'd1, s ^ 32'hA5A5_A5A5, s * 32'd3, ~s + 32'd7,
                s + 32'h1111_1111, {s[15:0], s[31:16]}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic evict(input logic [31:0] a, input logic [255:0] d, input bit hold_extra);
        l2_evict_write = 1'b1;
        l2_evict_addr  = a;
        l2_evict_wdata = d;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (evict_resp) break;
        end
        check("evict_resp", evict_resp, 1'b1);
        if (hold_extra) begin
            tick();
            check("resp_one_cycle", evict_resp, 1'b0);
        end
        l2_evict_write = 1'b0;
    endtask

    task automatic wait_ewb();
        for (int i = 0; i < 40; i++) begin
            if (ewb_write) break;
            tick();
        end
        check("ewb_write_seen", ewb_write, 1'b1);
    endtask

    task automatic drain_one();
        exp_t e;
        wait_ewb();
        e = '0;
        if (sb.size() > 0) e = sb.pop_front();
        check("ewb_addr", ewb_addr, e.addr);
        check("ewb_wdata", ewb_wdata, e.data);
        arb_ewb_resp = 1'b1;
        tick();
        arb_ewb_resp = 1'b0;
        check("retire_gap", ewb_write, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        l2_evict_write = 1'b0;
        l2_evict_addr  = '0;
        l2_evict_wdata = '0;
        lookup_addr    = 32'h0000_1040;
        arb_ewb_resp   = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_evict_resp", evict_resp, 1'b0);
        check("rst_ewb_write", ewb_write, 1'b0);
        check("rst_lookup_hit", lookup_hit, 1'b0);
        check("rst_lookup_rdata", lookup_rdata, '0);
        check("rst_empty", ewb_empty, 1'b1);
        check("rst_full", ewb_full, 1'b0);

        // Single eviction, request held across the resp cycle
        sb.push_back({32'h0000_1040, pat(32'h1)});
        evict(32'h0000_1040, pat(32'h1), 1'b1);
        check("t1_ewb_write", ewb_write, 1'b1);
        check("t1_lookup_hit", lookup_hit, 1'b1);
        check("t1_lookup_rdata", lookup_rdata, pat(32'h1));
        drain_one();
        check("t1_retire_not_empty", ewb_empty, 1'b0);
        tick();
        check("t1_empty", ewb_empty, 1'b1);

        // Fill to full, then a fifth eviction stalls until after the retire
        for (int i = 0; i < 4; i++) begin
            sb.push_back({32'h100 + 32'(i) * 32'h20, pat(32'h10 + 32'(i))});
            evict(32'h100 + 32'(i) * 32'h20, pat(32'h10 + 32'(i)), 1'b0);
        end
        check("t2_full", ewb_full, 1'b1);
        l2_evict_write = 1'b1;
        l2_evict_addr  = 32'h180;
        l2_evict_wdata = pat(32'h18);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_stall_no_resp", evict_resp, 1'b0);
        end
        sb.push_back({32'h180, pat(32'h18)});
        drain_one();
        check("t2_no_resp_retire", evict_resp, 1'b0);
        tick();
        check("t2_no_resp_same_edge", evict_resp, 1'b0);
        check("t2_not_full", ewb_full, 1'b0);
        tick();
        check("t2_resp_after_retire", evict_resp, 1'b1);
        l2_evict_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drain_one();
        end
        tick();
        check("t2_empty", ewb_empty, 1'b1);

        // Locked head: same line allocates a new entry, lookup gets the youngest
        sb.push_back({32'h200, pat(32'h20)});
        evict(32'h200, pat(32'h20), 1'b0);
        wait_ewb();
        sb.push_back({32'h200, pat(32'h22)});
        evict(32'h200, pat(32'h22), 1'b0);
        lookup_addr = 32'h21F;
        #1;
        check("t3_lookup_hit", lookup_hit, 1'b1);
        check("t3_lookup_rdata", lookup_rdata, pat(32'h22));
        drain_one();
        tick();
        check("t3_second_entry", ewb_empty, 1'b0);
        drain_one();
        tick();
        check("t3_empty", ewb_empty, 1'b1);

        // Non-head entry coalesces in place
        sb.push_back({32'h400, pat(32'h40)});
        evict(32'h400, pat(32'h40), 1'b0);
        wait_ewb();
        evict(32'h300, pat(32'h3), 1'b0);
        evict(32'h300, pat(32'h4), 1'b0);
        sb.push_back({32'h300, pat(32'h4)});
        lookup_addr = 32'h300;
        #1;
        check("t4_lookup_hit", lookup_hit, 1'b1);
        check("t4_lookup_rdata", lookup_rdata, pat(32'h4));
        drain_one();
        drain_one();
        tick();
        check("t4_empty", ewb_empty, 1'b1);

        // Reset during drain with three entries
        evict(32'h500, pat(32'h50), 1'b0);
        evict(32'h520, pat(32'h52), 1'b0);
        evict(32'h540, pat(32'h54), 1'b0);
        wait_ewb();
        #2;
        reset = 1'b1;
        #1;
        check("t5_ewb_write", ewb_write, 1'b0);
        check("t5_empty", ewb_empty, 1'b1);
        check("t5_full", ewb_full, 1'b0);
        for (int i = 0; i < 3; i++) begin
            lookup_addr = 32'h500 + 32'(i) * 32'h20;
            #1;
            check("t5_lookup_miss", lookup_hit, 1'b0);
        end
        tick();
        reset = 1'b0;
        tick();

        // Stray arbiter response while idle and empty
        arb_ewb_resp = 1'b1;
        tick();
        tick();
        arb_ewb_resp = 1'b0;
        check("t6_empty", ewb_empty, 1'b1);
        check("t6_ewb_write", ewb_write, 1'b0);
        check("t6_full", ewb_full, 1'b0);
        sb.push_back({32'h600, pat(32'h60)});
        evict(32'h600, pat(32'h60), 1'b0);
        drain_one();
        tick();
        check("t6_empty_after", ewb_empty, 1'b1);

        check("sb_drained", 256'(sb.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/l2_evict_buffer.md
Name: l2_evict_buffer

Overview:
- Multi-entry eviction write buffer between the L2 cache and the L2 memory arbiter.
- Accepts dirty-line evictions from L2 and drains them one at a time to the arbiter's ewb write port.
- Forwards buffered line data to L2 lookups so an L2 refill never reads a stale line from pmem.
- Coalesces a repeat eviction of the same line into its existing entry when that entry is not draining.

Parameters:
DEPTH  4  number of 256-bit line entries; power of two, minimum 2
PTR_W  $clog2(DEPTH)  pointer width (derived)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
l2_evict_write  input  1  L2 requests eviction; held high until evict_resp
l2_evict_addr  input  32  eviction address; bits [4:0] ignored
l2_evict_wdata  input  256  evicted line
evict_resp  output  1  one-cycle pulse: eviction accepted
lookup_addr  input  32  L2 lookup address; bits [4:0] ignored
lookup_hit  output  1  combinational: a valid entry holds lookup_addr's line
lookup_rdata  output  256  combinational: line data of the youngest matching entry
ewb_write  output  1  write request to arbiter
ewb_addr  output  32  head entry address, bits [4:0] driven 0
ewb_wdata  output  256  head entry data
arb_ewb_resp  input  1  arbiter write complete
ewb_empty  output  1  no valid entries
ewb_full  output  1  all DEPTH entries valid

Behaviour:
- Reset (async, active-high): all valid bits cleared; head, tail and count set to 0; drain FSM set to IDLE; evict_resp=0; ewb_write=0; lookup_hit=0; ewb_empty=1; ewb_full=0. Entry data is not reset.
- Line tag: addr[31:5]. All address compares use the tag only.
- Storage: circular FIFO of DEPTH entries, each holding {valid, tag, data}. Head and tail pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Enqueue handshake:
  - An acceptance edge is a posedge where l2_evict_write=1, evict_resp=0, and (coalesce target exists OR count<DEPTH).
  - evict_resp is registered and is 1 for exactly the cycle after an acceptance edge.
  - The cycle in which evict_resp=1 is never an acceptance edge, so one held request enqueues once.
  - When full with no coalesce target, the request waits. evict_resp stays 0 and no state changes.
- Coalesce:
  - Applies when a valid entry matches the eviction tag and that entry is not locked.
  - The entry at head is locked while the FSM is in DRAIN or RETIRE.
  - A coalesce overwrites that entry's data in place. Tail and count are unchanged.
  - Otherwise the eviction is written at tail, then tail advances and count increments.
- Drain FSM:
  - IDLE: ewb_write=0. Go to DRAIN when count>0.
  - DRAIN: ewb_write=1. ewb_addr and ewb_wdata come from head and stay stable. On arb_ewb_resp=1, go to RETIRE.
  - RETIRE: ewb_write=0 for this one cycle. Head entry is invalidated, head advances, count decrements. Go to IDLE.
  - Minimum one idle gap between successive ewb_write assertions.
  - arb_ewb_resp outside DRAIN is ignored.
- Simultaneous enqueue and retire in the same edge: both take effect; count is unchanged. If full at that edge, the enqueue still waits; it is accepted no earlier than the following edge.
- Forwarding:
  - lookup_hit/lookup_rdata are a combinational compare across all valid entries, including the locked head.
  - On multiple matches, the youngest entry (closest behind tail) wins.
  - lookup_rdata=0 when lookup_hit=0.
  - An eviction accepted at edge N is visible to lookups from cycle N+1.
- ewb_empty = (count==0); ewb_full = (count==DEPTH). Both are combinational from registered state.
- Reset mid-drain: buffer contents are discarded, ewb_write drops immediately, and the FSM goes to IDLE. Arbiter and L2 are reset by the same signal.

Test Plan:
- Reset, then one eviction addr 0x0000_1040 data D1 -> evict_resp pulses 1 cycle; next cycle ewb_write=1, ewb_addr=0x0000_1040, ewb_wdata=D1. After arb_ewb_resp, one RETIRE cycle with ewb_write=0, then ewb_empty=1.
- Hold arb_ewb_resp=0 and evict lines 0x100,0x120,0x140,0x160 -> ewb_full=1. A fifth eviction to 0x180 stalls with no evict_resp until the first retire. It is accepted on the edge after RETIRE.
- Entry for 0x200 held in DRAIN (locked); evict 0x200 again with D2 -> a new entry is allocated and count goes to 2. lookup_addr=0x21F gives lookup_hit=1, lookup_rdata=D2.
- Non-head entry for 0x300 with D3; evict 0x300 with D4 -> in-place coalesce, count unchanged; lookup returns D4. Only one ewb_write is issued for 0x300, carrying D4.
- Assert reset during DRAIN with 3 entries -> ewb_write=0 immediately, ewb_empty=1, lookup_hit=0 for all prior addresses.
- Pulse arb_ewb_resp while IDLE with count=0 -> no state change, no retire.
